act_wgt_loader: RTL and testbench

- Write-side initiator for the 32-bit activation/weight SRAM port of the core (cen_act_wgt, wen_act_wgt, addr_act_wgt, din_act_wgt).
- Accepts a load command (base address, word count) and a valid/ready stream of 32-bit words.
- Emits one registered SRAM write per accepted word at consecutive addresses, then signals completion.
- Sits between the host/testbench data source and the core.

---
 rtl/act_wgt_loader_pkg.sv | 16 +
 rtl/act_wgt_loader.sv | 122 ++++++++++++
 tb/tb_act_wgt_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/act_wgt_loader_pkg.sv
// Shared constants for the activation/weight SRAM write loader: bus widths,
// SRAM depth and FSM state encoding.
package act_wgt_loader_pkg;

  localparam int AWL_ADDR_W = 11;
  localparam int AWL_DATA_W = 32;
  // Must match the activation/weight SRAM macro instance.
  localparam int AWL_DEPTH  = 2000;

  localparam int AWL_STATE_W = 2;

  localparam logic [1:0] AWL_IDLE = 2'd0;
  localparam logic [1:0] AWL_LOAD = 2'd1;
  localparam logic [1:0] AWL_DONE = 2'd2;

endpackage

// File: rtl/act_wgt_loader.sv
// Write-side initiator for the activation/weight SRAM: takes a (base, len)
// command plus a valid/ready word stream and issues one registered write per word.
module act_wgt_loader
  import act_wgt_loader_pkg::*;
#(
  parameter int ADDR_W = AWL_ADDR_W,
  parameter int DATA_W = AWL_DATA_W,
  parameter int DEPTH  = AWL_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_base,
  input  logic [ADDR_W-1:0]      cmd_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   cen_act_wgt,
  output logic                   wen_act_wgt,
  output logic [ADDR_W-1:0]      addr_act_wgt,
  output logic [DATA_W-1:0]      din_act_wgt,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [AWL_STATE_W-1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. ready depends on state only; a source must hold valid and its
  // payload stable until it sees the transfer.

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   end_addr;

  // One extra bit so base+len past the top of the address space cannot wrap.
  assign end_addr = {1'b0, cmd_base} + {1'b0, cmd_len};

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    rem_d   = rem_q;
    cen_d   = 1'b1;
    wen_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = 1'b0;
    case (state_q)
      AWL_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            state_d = AWL_DONE;
          end else if (end_addr > DEPTH_LIM) begin
            err_d = 1'b1;
          end else begin
            state_d = AWL_LOAD;
            waddr_d = cmd_base;
            rem_d   = cmd_len;
          end
        end
      end
      AWL_LOAD: begin
        if (in_valid) begin
          cen_d   = 1'b0;
          wen_d   = 1'b0;
          addr_d  = waddr_q;
          din_d   = in_data;
          waddr_d = waddr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = AWL_DONE;
          end
        end
      end
      AWL_DONE: state_d = AWL_IDLE;
      default:  state_d = AWL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= AWL_IDLE;
      waddr_q <= '0;
      rem_q   <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      rem_q   <= rem_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready    = (state_q == AWL_IDLE);
  assign in_ready     = (state_q == AWL_LOAD);
  assign busy         = (state_q == AWL_LOAD);
  assign done         = (state_q == AWL_DONE);
  assign err          = err_q;
  assign cen_act_wgt  = cen_q;
  assign wen_act_wgt  = wen_q;
  assign addr_act_wgt = addr_q;
  assign din_act_wgt  = din_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_act_wgt_loader.sv
// Directed bench for act_wgt_loader with a behavioural SRAM on the write port.
module tb_act_wgt_loader;
  import act_wgt_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_base;
  logic [10:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        cen_act_wgt;
  logic        wen_act_wgt;
  logic [10:0] addr_act_wgt;
  logic [31:0] din_act_wgt;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int illegal_cnt = 0;
  logic [31:0] mem [0:1999];

  act_wgt_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cen_act_wgt(cen_act_wgt), .wen_act_wgt(wen_act_wgt),
    .addr_act_wgt(addr_act_wgt), .din_act_wgt(din_act_wgt),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: captures the strobe presented during the previous cycle.
  always @(posedge clk) begin
    if (reset && cen_act_wgt === 1'b0 && wen_act_wgt === 1'b0) begin
      mem[addr_act_wgt] <= din_act_wgt;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (reset && done === 1'b1) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    if (wen_act_wgt === 1'b0 && cen_act_wgt !== 1'b0) illegal_cnt <= illegal_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 2000; i++) mem[i] <= 32'h0;
    repeat (3) step();
    checks++; if (cen_act_wgt !== 1'b1 || wen_act_wgt !== 1'b1) begin errors++; $display("FAIL reset_cen_wen: got cen=%b wen=%b want 1 1", cen_act_wgt, wen_act_wgt); end
    checks++; if (addr_act_wgt !== 11'd0 || din_act_wgt !== 32'd0) begin errors++; $display("FAIL reset_addr_din: got addr=%0d din=%h want 0 0", addr_act_wgt, din_act_wgt); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b done=%b err=%b want 0 0 0", busy, done, err); end
    checks++; if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || dbg_state !== AWL_IDLE) begin errors++; $display("FAIL reset_state: got cmd_ready=%b in_ready=%b state=%0d want 1 0 %0d", cmd_ready, in_ready, dbg_state, AWL_IDLE); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_burst();
    logic [31:0] words [4];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC; words[3] = 32'hD;
    cmd_valid = 1'b1; cmd_base = 11'd0; cmd_len = 11'd4;
    step();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || cmd_ready !== 1'b0 || cen_act_wgt !== 1'b1) begin errors++; $display("FAIL burst_accept: got busy=%b in_ready=%b cmd_ready=%b cen=%b want 1 1 0 1", busy, in_ready, cmd_ready, cen_act_wgt); end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = words[i];
      step();
      checks++; if (cen_act_wgt !== 1'b0 || wen_act_wgt !== 1'b0 || addr_act_wgt !== 11'(i) || din_act_wgt !== words[i]) begin errors++; $display("FAIL burst_write%0d: got cen=%b wen=%b addr=%0d din=%h want 0 0 %0d %h", i, cen_act_wgt, wen_act_wgt, addr_act_wgt, din_act_wgt, i, words[i]); end
      checks++; if (done !== (i == 3) || busy !== (i != 3)) begin errors++; $display("FAIL burst_done%0d: got done=%b busy=%b want %b %b", i, done, busy, i == 3, i != 3); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (done !== 1'b0 || cen_act_wgt !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL burst_idle: got done=%b cen=%b cmd_ready=%b want 0 1 1", done, cen_act_wgt, cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[i] !== words[i]) begin errors++; $display("FAIL burst_mem%0d: got %h want %h", i, mem[i], words[i]); end
    end
  endtask

  task automatic test_gaps();
    logic pat [5];
    int w;
    int s0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
    s0 = strobe_cnt;
    w = 0;
    cmd_valid = 1'b1; cmd_base = 11'd100; cmd_len = 11'd3;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = pat[k];
      in_data = 32'h100 + 32'(k);
      step();
      if (pat[k]) begin
        checks++; if (cen_act_wgt !== 1'b0 || wen_act_wgt !== 1'b0 || addr_act_wgt !== 11'(100 + w) || din_act_wgt !== 32'h100 + 32'(k)) begin errors++; $display("FAIL gaps_write%0d: got cen=%b wen=%b addr=%0d din=%h want 0 0 %0d %h", k, cen_act_wgt, wen_act_wgt, addr_act_wgt, din_act_wgt, 100 + w, 32'h100 + 32'(k)); end
        w++;
      end else begin
        checks++; if (cen_act_wgt !== 1'b1 || wen_act_wgt !== 1'b1 || addr_act_wgt !== 11'(100 + w - 1)) begin errors++; $display("FAIL gaps_idle%0d: got cen=%b wen=%b addr=%0d want 1 1 %0d", k, cen_act_wgt, wen_act_wgt, addr_act_wgt, 100 + w - 1); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b want 1", done); end
    in_valid = 1'b0;
    step();
    checks++; if (strobe_cnt - s0 !== 3) begin errors++; $display("FAIL gaps_strobes: got %0d want 3", strobe_cnt - s0); end
    checks++; if (mem[101] !== 32'h102 || mem[102] !== 32'h104) begin errors++; $display("FAIL gaps_mem: got %h %h want 102 104", mem[101], mem[102]); end
  endtask

  task automatic test_bounds();
    int s0;
    s0 = strobe_cnt;
    cmd_valid = 1'b1; cmd_base = 11'd1998; cmd_len = 11'd3;
    step();
    cmd_valid = 1'b0;
    checks++; if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || cen_act_wgt !== 1'b1) begin errors++; $display("FAIL bounds_err: got err=%b cmd_ready=%b busy=%b cen=%b want 1 1 0 1", err, cmd_ready, busy, cen_act_wgt); end
    step();
    checks++; if (err !== 1'b0 || done !== 1'b0 || strobe_cnt !== s0) begin errors++; $display("FAIL bounds_after: got err=%b done=%b strobes=%0d want 0 0 %0d", err, done, strobe_cnt, s0); end
    cmd_valid = 1'b1; cmd_base = 11'd1998; cmd_len = 11'd2;
    step();
    cmd_valid = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bounds_edge_accept: got err=%b busy=%b want 0 1", err, busy); end
    in_valid = 1'b1; in_data = 32'hCAFE0001;
    step();
    checks++; if (cen_act_wgt !== 1'b0 || addr_act_wgt !== 11'd1998 || done !== 1'b0) begin errors++; $display("FAIL bounds_w0: got cen=%b addr=%0d done=%b want 0 1998 0", cen_act_wgt, addr_act_wgt, done); end
    in_data = 32'hCAFE0002;
    step();
    checks++; if (cen_act_wgt !== 1'b0 || addr_act_wgt !== 11'd1999 || done !== 1'b1) begin errors++; $display("FAIL bounds_w1: got cen=%b addr=%0d done=%b want 0 1999 1", cen_act_wgt, addr_act_wgt, done); end
    in_valid = 1'b0;
    step();
    checks++; if (mem[1998] !== 32'hCAFE0001 || mem[1999] !== 32'hCAFE0002) begin errors++; $display("FAIL bounds_mem: got %h %h want cafe0001 cafe0002", mem[1998], mem[1999]); end
  endtask

  task automatic test_zero_len();
    int s0;
    s0 = strobe_cnt;
    cmd_valid = 1'b1; cmd_base = 11'd5; cmd_len = 11'd0;
    step();
    cmd_valid = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || cen_act_wgt !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b err=%b cen=%b cmd_ready=%b want 1 0 0 1 0", done, busy, err, cen_act_wgt, cmd_ready); end
    step();
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || strobe_cnt !== s0) begin errors++; $display("FAIL zero_after: got done=%b cmd_ready=%b strobes=%0d want 0 1 %0d", done, cmd_ready, strobe_cnt, s0); end
  endtask

  task automatic test_reset_mid_load();
    int d0;
    mem[12] <= 32'h5A5A5A5A;
    cmd_valid = 1'b1; cmd_base = 11'd10; cmd_len = 11'd5;
    step();
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_data = 32'h1111;
    step();
    in_data = 32'h2222;
    step();
    in_valid = 1'b0;
    step();
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cen_act_wgt !== 1'b1 || wen_act_wgt !== 1'b1 || addr_act_wgt !== 11'd0 || din_act_wgt !== 32'd0) begin errors++; $display("FAIL rstmid_outputs: got busy=%b cen=%b wen=%b addr=%0d din=%h want 0 1 1 0 0", busy, cen_act_wgt, wen_act_wgt, addr_act_wgt, din_act_wgt); end
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (done_cnt !== d0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_nodone: got dones=%0d cmd_ready=%b want %0d 1", done_cnt, cmd_ready, d0); end
    checks++; if (mem[10] !== 32'h1111 || mem[11] !== 32'h2222 || mem[12] !== 32'h5A5A5A5A) begin errors++; $display("FAIL rstmid_mem: got %h %h %h want 1111 2222 5a5a5a5a", mem[10], mem[11], mem[12]); end
  endtask

  task automatic test_cmd_during_load();
    cmd_valid = 1'b1; cmd_base = 11'd200; cmd_len = 11'd3;
    step();
    cmd_base = 11'd300; cmd_len = 11'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h200 + 32'(i);
      step();
      checks++; if (addr_act_wgt !== 11'(200 + i) || cen_act_wgt !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL ovl_first%0d: got addr=%0d cen=%b cmd_ready=%b want %0d 0 0", i, addr_act_wgt, cen_act_wgt, cmd_ready, 200 + i); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovl_idle: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy); end
    step();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_second_accept: got busy=%b want 1", busy); end
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'h300 + 32'(i);
      step();
      checks++; if (addr_act_wgt !== 11'(300 + i) || done !== (i == 1)) begin errors++; $display("FAIL ovl_second%0d: got addr=%0d done=%b want %0d %b", i, addr_act_wgt, done, 300 + i, i == 1); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (mem[202] !== 32'h202 || mem[301] !== 32'h301) begin errors++; $display("FAIL ovl_mem: got %h %h want 202 301", mem[202], mem[301]); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_gaps();
    test_bounds();
    test_zero_len();
    test_reset_mid_load();
    test_cmd_during_load();
    checks++; if (illegal_cnt !== 0) begin errors++; $display("FAIL wen_without_cen: got %0d cycles want 0", illegal_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
